// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the FIFO word packer: default widths and FSM state encoding.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_PACK       = 4;

    // Packer control states.
    typedef enum logic [1:0] {
        ST_FILL       = 2'd0,
        ST_HOLD       = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } pack_state_e;

endpackage

// File: rtl/pack_out_reg.sv
// Output register for the packed word: loads when empty or being drained,
// holds data/keep stable while the downstream stalls.
module pack_out_reg
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PACK       = DEFAULT_PACK
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load_i,
    input  logic [DATA_WIDTH*PACK-1:0] data_i,
    input  logic [PACK-1:0]            keep_i,
    input  logic                       m_ready_i,
    output logic                       can_load_o,
    output logic                       m_valid_o,
    output logic [DATA_WIDTH*PACK-1:0] m_data_o,
    output logic [PACK-1:0]            m_keep_o
);

    logic                       valid_q, valid_d;
    logic [DATA_WIDTH*PACK-1:0] data_q,  data_d;
    logic [PACK-1:0]            keep_q,  keep_d;

    // The register may take a new word when it is empty or its word leaves this cycle.
    assign can_load_o = !valid_q || m_ready_i;

    // Next-state: load a new word, drop valid after a handshake, otherwise hold.
    always_comb begin
        // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        if (load_i && can_load_o) begin
            valid_d = 1'b1;
            data_d  = data_i;
            keep_d  = keep_i;
        end else if (m_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the wide data register is reset too, because m_data must read zero during reset.
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end

    assign m_valid_o = valid_q;
    assign m_data_o  = data_q;
    assign m_keep_o  = keep_q;

endmodule

// File: rtl/fifo_word_packer.sv
// Reads bytes from an upstream sync FIFO, packs PACK of them (lane 0 first)
// into one word, and hands full or flushed partial words to pack_out_reg.
module fifo_word_packer
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PACK       = DEFAULT_PACK
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]      fifo_dout,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       busy
);

    localparam int              CNT_W    = $clog2(PACK + 1);
    localparam logic [CNT_W:0]  PACK_LVL = (CNT_W + 1)'(PACK);
    localparam logic [CNT_W-1:0] PACK_CNT = CNT_W'(PACK);

    pack_state_e                state_q, state_d;
    logic [DATA_WIDTH*PACK-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]           acc_cnt_q, acc_cnt_d;
    logic                       inflight_q, inflight_d;
    logic                       flush_pend_q, flush_pend_d;
    logic                       rd_ok_q;

    logic [CNT_W:0]   fill_lvl;
    logic [CNT_W-1:0] wr_lane;
    logic [PACK-1:0]  keep_mask;
    logic             can_load;
    logic             transfer;
    logic             flush_take;
    logic             rd_en;

    // Bytes committed to the current word: landed plus the one still in flight.
    assign fill_lvl   = {1'b0, acc_cnt_q} + {{CNT_W{1'b0}}, inflight_q};
    assign transfer   = (state_q == ST_HOLD) && can_load;
    assign flush_take = flush && (state_q == ST_FILL) && (fill_lvl != '0);

    // Reads are gated by reset and by a flop that only opens on the first edge after release.
    assign rd_en = reset_n && rd_ok_q && !fifo_empty && !flush_pend_q && !flush_take &&
                   ((fill_lvl < PACK_LVL) || transfer);
    assign fifo_rd_en = rd_en;

    // A landing byte goes to lane 0 when the word leaves in the same cycle.
    assign wr_lane = transfer ? '0 : acc_cnt_q;

    // Keep mask: the low acc_cnt lanes, which is all ones for a full word.
    always_comb begin
        keep_mask = '0;
        for (int i = 0; i < PACK; i++) begin
            keep_mask[i] = (CNT_W'(i) < acc_cnt_q);
        end
    end

    // Next-state for the accumulator, counters, flush flag and FSM.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        inflight_d   = rd_en;
        flush_pend_d = flush_pend_q;

        if (transfer) begin
            acc_d        = '0;
            acc_cnt_d    = '0;
            flush_pend_d = 1'b0;
            state_d      = ST_FILL;
        end

        if (inflight_q) begin
            for (int i = 0; i < PACK; i++) begin
                if (wr_lane == CNT_W'(i)) begin
                    acc_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
                end
            end
            acc_cnt_d = wr_lane + CNT_W'(1);
        end

        if (flush_take) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            ST_FILL: begin
                if (acc_cnt_d == PACK_CNT) begin
                    state_d = ST_HOLD;
                end else if (flush_take) begin
                    state_d = ST_FLUSH_WAIT;
                end
            end
            ST_FLUSH_WAIT: begin
                if (!inflight_q) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
            end
            default: state_d = ST_FILL;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator, counters, flush flag and read-enable gate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            rd_ok_q      <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            inflight_q   <= inflight_d;
            flush_pend_q <= flush_pend_d;
            rd_ok_q      <= 1'b1;
        end
    end

    pack_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK       (PACK)
    ) u_out_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (transfer),
        .data_i     (acc_q),
        .keep_i     (keep_mask),
        .m_ready_i  (m_ready),
        .can_load_o (can_load),
        .m_valid_o  (m_valid),
        .m_data_o   (m_data),
        .m_keep_o   (m_keep)
    );

    assign busy = inflight_q || (acc_cnt_q != '0) || m_valid;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: an upstream sync-FIFO model, a
// byte-stream reference model that groups bytes into expected words, and a
// monitor that pops the expected words on every output handshake.
module tb_fifo_word_packer;

    localparam int DW = 8;
    localparam int PK = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            fifo_empty;
    logic            fifo_rd_en;
    logic [DW-1:0]   fifo_dout;
    logic            flush;
    logic            m_valid;
    logic            m_ready;
    logic [DW*PK-1:0] m_data;
    logic [PK-1:0]   m_keep;
    logic            busy;

    fifo_word_packer #(
        .DATA_WIDTH (DW),
        .PACK       (PK)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int rd_count = 0;
    bit gate     = 1'b0;

    logic [DW-1:0]    fifo_q[$];   // bytes still inside the upstream FIFO
    logic [DW-1:0]    pend_q[$];   // bytes not yet assigned to an expected word
    logic [DW*PK-1:0] exp_data_q[$];
    logic [PK-1:0]    exp_keep_q[$];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: the byte stream is cut into words of PK bytes, lane 0 first.
    task automatic emit_word();
        logic [DW*PK-1:0] d;
        logic [PK-1:0]    k;
        d = '0;
        k = '0;
        for (int i = 0; i < pend_q.size(); i++) begin
            d = d | ((DW*PK)'(pend_q[i]) << (DW * i));
            k[i] = 1'b1;
        end
        exp_data_q.push_back(d);
        exp_keep_q.push_back(k);
        pend_q.delete();
    endtask

    task automatic update_empty();
        fifo_empty = (fifo_q.size() == 0) || gate;
    endtask

    task automatic push_byte(input logic [DW-1:0] b);
        fifo_q.push_back(b);
        pend_q.push_back(b);
        if (pend_q.size() == PK) emit_word();
        update_empty();
    endtask

    task automatic set_gate(input bit g);
        gate = g;
        update_empty();
    endtask

    // One clock cycle: sample the read strobe mid-cycle, then return FIFO data after the edge.
    task automatic cycle();
        bit rd_seen;
        @(negedge clk);
        rd_seen = fifo_rd_en;
        if (rd_seen) begin
            rd_count++;
            check("rd_while_empty", fifo_empty, 0);
        end
        @(posedge clk);
        #1;
        if (rd_seen && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        flush = 1'b0;
        update_empty();
    endtask

    task automatic flush_pulse();
        if (pend_q.size() > 0) emit_word();
        flush = 1'b1;
        cycle();
    endtask

    // Let every pushed byte reach the accumulator (gate open).
    task automatic quiesce(input bit rnd_ready);
        int n = 0;
        set_gate(1'b0);
        while (fifo_q.size() != 0 && n < 500) begin
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        check("quiesce_fifo_left", fifo_q.size(), 0);
        repeat (3) cycle();
    endtask

    task automatic drain(input string name);
        int n = 0;
        m_ready = 1'b1;
        set_gate(1'b0);
        while ((fifo_q.size() != 0 || exp_data_q.size() != 0) && n < 500) begin
            cycle();
            n++;
        end
        check(name, exp_data_q.size(), 0);
        cycle();
    endtask

    // Monitor: compare each accepted word against the scoreboard; check stall stability.
    task automatic monitor();
        bit               stall_prev = 1'b0;
        logic [DW*PK-1:0] d_prev = '0;
        logic [PK-1:0]    k_prev = '0;
        logic [DW*PK-1:0] ed;
        logic [PK-1:0]    ek;
        forever begin
            @(negedge clk);
            if (stall_prev && reset_n) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, d_prev);
                check("stall_keep", m_keep, k_prev);
            end
            if (m_valid && m_ready) begin
                check("word_expected", exp_data_q.size() != 0, 1);
                if (exp_data_q.size() != 0) begin
                    ed = exp_data_q.pop_front();
                    ek = exp_keep_q.pop_front();
                    check("word_data", m_data, ed);
                    check("word_keep", m_keep, ek);
                end
            end
            stall_prev = m_valid && !m_ready && reset_n;
            d_prev     = m_data;
            k_prev     = m_keep;
        end
    endtask

    initial begin
        int rd0;
        int n;
        reset_n    = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        flush      = 1'b0;
        m_ready    = 1'b1;

        fork
            monitor();
        join_none

        // Reset with the FIFO already holding the first word's bytes.
        repeat (2) cycle();
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        repeat (2) cycle();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_keep", m_keep, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        #1;
        check("rd_before_first_edge", fifo_rd_en, 0);
        cycle();
        check("rd_after_first_edge", fifo_rd_en, 1);
        drain("drain_basic_word");

        // Partial word via flush.
        push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
        quiesce(1'b0);
        check("partial_busy", busy, 1);
        flush_pulse();
        drain("drain_flush_word");
        check("busy_after_flush", busy, 0);

        // Flush with nothing accumulated does nothing.
        flush_pulse();
        repeat (4) cycle();
        check("noop_flush_valid", m_valid, 0);
        check("noop_flush_busy", busy, 0);

        // Downstream stall with 12 bytes queued.
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) push_byte(8'(i));
        repeat (10) cycle();
        check("stalled_valid", m_valid, 1);
        check("stalled_keep", m_keep, 4'hF);
        drain("drain_stall_words");

        // fifo_empty toggling every 2 cycles over 8 bytes.
        rd0 = rd_count;
        for (int i = 0; i < 8; i++) push_byte(8'h80 + 8'(i));
        set_gate(1'b1);
        n = 0;
        while (fifo_q.size() != 0 && n < 200) begin
            if (n % 2 == 1) set_gate(!gate);
            cycle();
            n++;
        end
        drain("drain_gated_words");
        check("gated_rd_count", rd_count - rd0, 8);

        // Reset in the middle of a word discards the accumulated bytes.
        push_byte(8'h5A); push_byte(8'h6B);
        repeat (4) cycle();
        reset_n = 1'b0;
        pend_q.delete();
        push_byte(8'hC0); push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
        cycle();
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_data", m_data, 0);
        check("midrst_m_keep", m_keep, 0);
        check("midrst_rd_en", fifo_rd_en, 0);
        check("midrst_busy", busy, 0);
        reset_n = 1'b1;
        drain("drain_after_reset");

        // Continuous stream: PK reads per PK+1 cycles.
        for (int i = 0; i < 60; i++) push_byte(8'($urandom));
        repeat (8) cycle();
        rd0 = rd_count;
        repeat (20) cycle();
        check("stream_rate", rd_count - rd0, 16);
        drain("drain_stream");

        // Randomized traffic: random bursts, ready, empty gating and flushes.
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) push_byte(8'($urandom));
            n = 0;
            while (fifo_q.size() != 0 && n < 400) begin
                m_ready = 1'($urandom_range(0, 1));
                set_gate($urandom_range(0, 3) == 0);
                cycle();
                n++;
            end
            quiesce(1'b1);
            if ($urandom_range(0, 1) == 1) flush_pulse();
        end
        quiesce(1'b1);
        flush_pulse();
        drain("drain_random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
